cfg_scan_loader: RTL and testbench
==================================

Name: cfg_scan_loader

Overview:
- Configuration-load stage directly upstream of the CLB scan chain.
- Accepts configuration words over a valid/ready handshake and serializes them LSB-first onto the chain's serial input.
- Drives the chain's scan enable for exactly CHAIN_LEN shift cycles per load.
- Captures the bits falling out of the chain tail and returns them as readback words, so the previous configuration can be checked.

Parameters:
- DATA_WIDTH, 8, configuration word width on din / rb_data.
- CHAIN_LEN, 29, total scan bits in the driven chain. Default is one CLB: 1 mode bit + 12 connection-select bits + 16 LUT bits.
- CNT_WIDTH, 16, width of the internal bit counter. Must satisfy 2**CNT_WIDTH > CHAIN_LEN.

Ports:
- clk  input  1  single clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load. Sampled only in IDLE.
- din  input  DATA_WIDTH  configuration word. Bit 0 is shifted first.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  loader accepts din this cycle.
- cfg_scan_out  output  1  serial data to the chain's scan_in.
- cfg_scan_en  output  1  scan enable to the chain; the chain shifts one bit per cycle while high.
- cfg_scan_ret  input  1  chain tail (scan_out of the last chain element).
- rb_data  output  DATA_WIDTH  readback word of bits shifted out of the chain.
- rb_valid  output  1  one-cycle strobe qualifying rb_data.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  sticky completion flag. Cleared by the next accepted start or by rst.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; bit_cnt=0; word shifter=0; rb shifter=0.
  - Outputs: din_ready=0, cfg_scan_en=0, cfg_scan_out=0, rb_valid=0, rb_data=0, busy=0, done=0.
  - Applies from any state, including mid-shift. The partially loaded chain is left as-is and cfg_scan_en is low on the next cycle.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - All handshake and scan outputs are low.
  - start=1 → FETCH next cycle; bit_cnt←0; done←0.
- FETCH:
  - din_ready=1, cfg_scan_en=0.
  - On din_valid&din_ready: latch din into the word shifter, reset the per-word bit index to 0, go to SHIFT.
  - din_valid low: stay in FETCH indefinitely. The chain holds because scan_en is low.
- SHIFT:
  - cfg_scan_en=1; cfg_scan_out=shifter[0] (combinational from the register); din_ready=0.
  - Each cycle: shifter shifts right by 1, bit_cnt+1, word index+1, and cfg_scan_ret is sampled into rb shifter position [word index].
  - Exit when bit_cnt+1==CHAIN_LEN on this cycle → DONE.
  - Otherwise, exit when word index+1==DATA_WIDTH → FETCH.
  - A word is partial only on the last transfer; its unused upper bits are never shifted.
- DONE:
  - cfg_scan_en=0; done←1; busy←0; back to IDLE next cycle. done stays 1 in IDLE.
- Readback:
  - rb_valid pulses the cycle after a word's final shift, whether it completed all DATA_WIDTH bits or is the final partial word.
  - rb_data holds the captured bits, with unused bits 0. The rb shifter clears after each strobe.
  - Readback bit k is the chain-tail value sampled on the k-th shift, i.e. before the shifting edge.
- Counts:
  - Words consumed per load = ceil(CHAIN_LEN/DATA_WIDTH).
  - cfg_scan_en high cycles = exactly CHAIN_LEN.
  - Minimum load time = CHAIN_LEN + words + 2 cycles.
- Bit ordering: after a complete load, stream bit 0 sits in the element nearest the chain tail and bit CHAIN_LEN-1 sits nearest the chain head.
- Boundaries:
  - start while busy: ignored.
  - din_valid outside FETCH: ignored; din_ready is never 1 there.
  - CHAIN_LEN an exact multiple of DATA_WIDTH: no partial word; the DONE transition coincides with the word-end.
  - CHAIN_LEN<DATA_WIDTH: a single partial word.
  - bit_cnt never wraps; it saturates at CHAIN_LEN.

Test Plan:
- Basic load (DATA_WIDTH=8, CHAIN_LEN=29, din_valid always high): start, words 0xA5, 0x3C, 0xFF, 0x12 → exactly 4 din handshakes and 29 cfg_scan_en cycles. The serial stream is A5/3C/FF LSB-first, then 0x12 bits 0-4 only. done=1 and busy=0 afterward.
- Readback with a 29-bit chain model preloaded with all-ones: load all-zero words → rb_valid four times with rb_data 0xFF, 0xFF, 0xFF, 0x1F. A second load returns 0x00 ×4.
- Stall: hold din_valid low 5 cycles before word 2 → cfg_scan_en low throughout the stall, chain contents unchanged, final chain image identical to the no-stall case.
- Reset mid-operation: assert rst after 12 shifts → next cycle state is IDLE and all outputs are 0. A fresh start reloads all 29 bits correctly.
- Ignored events: start pulsed during SHIFT → no restart and bit count still 29. din_valid high in IDLE → din_ready stays 0 and no word is consumed.
- Exact multiple (CHAIN_LEN=16): two words, 16 shift cycles, two full rb_valid strobes, no partial word.

Source files
------------

// File: rtl/cfg_scan_loader.sv
// Configuration loader feeding the CLB scan chain: serializes handshaken words
// LSB-first onto scan_in and returns the bits leaving the chain tail as readback words.
`timescale 1ns/1ps
module cfg_scan_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int CHAIN_LEN  = 29,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  cfg_scan_out,
    output logic                  cfg_scan_en,
    input  logic                  cfg_scan_ret,
    output logic [DATA_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CHAIN_LEN);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] word_sh;
    logic [DATA_WIDTH-1:0] rb_sh;
    logic [DATA_WIDTH-1:0] rb_cap;
    logic                  last_bit;
    logic                  word_end;

    // Bit counter holds at CHAIN_LEN instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v >= FULL_CNT) begin
            return FULL_CNT;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    assign last_bit = (bit_cnt == LAST_BIT);
    assign word_end = (word_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        din_ready    = 1'b0;
        cfg_scan_en  = 1'b0;
        cfg_scan_out = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cfg_scan_en  = 1'b1;
                cfg_scan_out = word_sh[0];
                busy         = 1'b1;
                // Chain end takes priority so a final partial word never refetches.
                if (last_bit) begin
                    state_nxt = DONE;
                end else if (word_end) begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tail bit lands at the current word position; everything else keeps its value.
    always_comb begin
        rb_cap = rb_sh;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (word_idx == IDX_W'(i)) begin
                rb_cap[i] = cfg_scan_ret;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            word_idx <= '0;
            word_sh  <= '0;
            rb_sh    <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        done    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (din_valid) begin
                        word_sh  <= din;
                        word_idx <= '0;
                    end
                end
                SHIFT: begin
                    word_sh  <= word_sh >> 1;
                    bit_cnt  <= sat_inc(bit_cnt);
                    word_idx <= word_idx + IDX_W'(1);
                    if (last_bit || word_end) begin
                        rb_data  <= rb_cap;
                        rb_valid <= 1'b1;
                        rb_sh    <= '0;
                    end else begin
                        rb_sh <= rb_cap;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Directed bench for cfg_scan_loader: 29-bit chain model on the main instance,
// 16-bit chain model on a second instance for the exact-multiple case.
`timescale 1ns/1ps
module tb_cfg_scan_loader;

    localparam int DW   = 8;
    localparam int CL   = 29;
    localparam int CL16 = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          cfg_scan_out;
    logic          cfg_scan_en;
    logic          cfg_scan_ret;
    logic [DW-1:0] rb_data;
    logic          rb_valid;
    logic          busy;
    logic          done;

    logic          start16;
    logic [DW-1:0] din16;
    logic          din_valid16;
    logic          din_ready16;
    logic          scan_out16;
    logic          scan_en16;
    logic          scan_ret16;
    logic [DW-1:0] rb_data16;
    logic          rb_valid16;
    logic          busy16;
    logic          done16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cfg_scan_loader #(.DATA_WIDTH(DW), .CHAIN_LEN(CL), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .cfg_scan_out(cfg_scan_out), .cfg_scan_en(cfg_scan_en),
        .cfg_scan_ret(cfg_scan_ret), .rb_data(rb_data), .rb_valid(rb_valid),
        .busy(busy), .done(done)
    );

    cfg_scan_loader #(.DATA_WIDTH(DW), .CHAIN_LEN(CL16), .CNT_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .din(din16), .din_valid(din_valid16),
        .din_ready(din_ready16), .cfg_scan_out(scan_out16), .cfg_scan_en(scan_en16),
        .cfg_scan_ret(scan_ret16), .rb_data(rb_data16), .rb_valid(rb_valid16),
        .busy(busy16), .done(done16)
    );

    // Chain models: element 0 is the tail, shifting toward it while scan_en is high.
    logic [CL-1:0]   chain;
    logic [CL-1:0]   chain_init;
    logic            chain_ld;
    logic [CL16-1:0] chain16;
    logic [CL16-1:0] chain16_init;
    logic            chain16_ld;

    assign cfg_scan_ret = chain[0];
    assign scan_ret16   = chain16[0];

    always @(posedge clk) begin
        if (chain_ld) chain <= chain_init;
        else if (cfg_scan_en) chain <= {cfg_scan_out, chain[CL-1:1]};
        if (chain16_ld) chain16 <= chain16_init;
        else if (scan_en16) chain16 <= {scan_out16, chain16[CL16-1:1]};
    end

    int         hs_cnt = 0, en_cnt = 0, rb_cnt = 0;
    int         hs16_cnt = 0, en16_cnt = 0, rb16_cnt = 0;
    logic [7:0] rb_log[64];
    logic [7:0] rb16_log[8];

    always @(posedge clk) begin
        if (din_valid && din_ready) hs_cnt <= hs_cnt + 1;
        if (cfg_scan_en) en_cnt <= en_cnt + 1;
        if (rb_valid) begin
            if (rb_cnt < 64) rb_log[rb_cnt] <= rb_data;
            rb_cnt <= rb_cnt + 1;
        end
        if (din_valid16 && din_ready16) hs16_cnt <= hs16_cnt + 1;
        if (scan_en16) en16_cnt <= en16_cnt + 1;
        if (rb_valid16) begin
            if (rb16_cnt < 8) rb16_log[rb16_cnt] <= rb_data16;
            rb16_cnt <= rb16_cnt + 1;
        end
    end

    typedef struct packed {
        logic [31:0] words;      // word i in bits [8i+7:8i]
        int          stall_word; // 0 = no stall
        int          stall_len;
        logic        poke;       // pulse start once during SHIFT
        logic        pre_en;
        logic [28:0] pre;
        logic [28:0] exp_chain;
        logic [31:0] exp_rb;     // readback word i in bits [8i+7:8i]
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_din_ready"}, din_ready, 0);
        check({tag, "_scan_en"}, cfg_scan_en, 0);
        check({tag, "_scan_out"}, cfg_scan_out, 0);
        check({tag, "_rb_valid"}, rb_valid, 0);
        check({tag, "_rb_data"}, rb_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic do_load(input int vi);
        vec_t          v = vecs[vi];
        int            hs0, en0, rb0, wi, stall;
        logic          hs_next;
        logic          poked;
        logic [CL-1:0] snap;
        if (v.pre_en) begin
            @(negedge clk);
            chain_init = v.pre;
            chain_ld   = 1'b1;
            @(negedge clk);
            chain_ld = 1'b0;
        end
        @(negedge clk);
        hs0 = hs_cnt; en0 = en_cnt; rb0 = rb_cnt;
        wi = 0; stall = 0; poked = 1'b0; snap = '0;
        start = 1'b1; din = v.words[7:0]; din_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_after_start", vi), busy, 1);
        check($sformatf("v%0d_ready_in_fetch", vi), din_ready, 1);
        check($sformatf("v%0d_done_cleared", vi), done, 0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            hs_next = din_valid && din_ready;
            if (v.poke && !poked && cfg_scan_en) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (hs_next) begin
                wi++;
                if (wi < 4) begin
                    din = v.words[8*wi +: 8];
                    if (wi == v.stall_word) begin
                        din_valid = 1'b0;
                        stall     = v.stall_len;
                    end
                end else begin
                    din_valid = 1'b0;
                end
            end else if (stall > 0 && din_ready) begin
                if (stall == v.stall_len) snap = chain;
                else check($sformatf("v%0d_stall_chain_hold", vi), chain, snap);
                check($sformatf("v%0d_stall_scan_en", vi), cfg_scan_en, 0);
                stall--;
                if (stall == 0) din_valid = 1'b1;
            end
        end
        din_valid = 1'b0;
        check($sformatf("v%0d_done", vi), done, 1);
        check($sformatf("v%0d_busy_end", vi), busy, 0);
        check($sformatf("v%0d_handshakes", vi), hs_cnt - hs0, 4);
        check($sformatf("v%0d_scan_en_cycles", vi), en_cnt - en0, CL);
        check($sformatf("v%0d_rb_strobes", vi), rb_cnt - rb0, 4);
        check($sformatf("v%0d_chain_image", vi), chain, v.exp_chain);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("v%0d_rb_word%0d", vi, i), rb_log[rb0 + i], v.exp_rb[8*i +: 8]);
        end
    endtask

    initial begin
        int en0;
        int hs0;
        vecs[0] = '{words:32'h12FF3CA5, stall_word:0, stall_len:0, poke:1'b0, pre_en:1'b1,
                    pre:29'h0, exp_chain:29'h12FF3CA5, exp_rb:32'h0};
        vecs[1] = '{words:32'h0, stall_word:0, stall_len:0, poke:1'b0, pre_en:1'b1,
                    pre:29'h1FFFFFFF, exp_chain:29'h0, exp_rb:32'h1FFFFFFF};
        vecs[2] = '{words:32'h0, stall_word:0, stall_len:0, poke:1'b0, pre_en:1'b0,
                    pre:29'h0, exp_chain:29'h0, exp_rb:32'h0};
        vecs[3] = '{words:32'h12FF3CA5, stall_word:2, stall_len:5, poke:1'b0, pre_en:1'b1,
                    pre:29'h0ABCDE01, exp_chain:29'h12FF3CA5, exp_rb:32'h0ABCDE01};
        vecs[4] = '{words:32'h7F96C33C, stall_word:0, stall_len:0, poke:1'b1, pre_en:1'b1,
                    pre:29'h15555555, exp_chain:29'h1F96C33C, exp_rb:32'h15555555};

        rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
        start16 = 1'b0; din16 = '0; din_valid16 = 1'b0;
        chain_init = '0; chain_ld = 1'b1; chain16_init = '0; chain16_ld = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0; chain_ld = 1'b0; chain16_ld = 1'b0;

        do_load(0);

        // din_valid while idle must not be consumed
        @(negedge clk);
        hs0 = hs_cnt; din = 8'h77; din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_din_ready", din_ready, 0);
        end
        din_valid = 1'b0;
        check("idle_no_handshake", hs_cnt - hs0, 0);

        for (int i = 1; i < 5; i++) do_load(i);

        // Reset in the middle of the second word
        @(negedge clk);
        en0 = en_cnt; start = 1'b1; din = 8'hA5; din_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && (en_cnt - en0) < 12; c++) @(negedge clk);
        check("pre_reset_shifts", en_cnt - en0, 12);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0; din_valid = 1'b0;
        do_load(0);

        // Exact multiple: 16-bit chain, two full words
        @(negedge clk);
        chain16_init = 16'hBEEF; chain16_ld = 1'b1;
        @(negedge clk);
        chain16_ld = 1'b0;
        start16 = 1'b1; din16 = 8'h5A; din_valid16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        begin
            int   w16;
            logic hs;
            w16 = 0;
            for (int c = 0; c < 100 && !done16; c++) begin
                hs = din_valid16 && din_ready16;
                @(negedge clk);
                if (hs) begin
                    w16++;
                    if (w16 == 1) din16 = 8'hC3;
                    else din_valid16 = 1'b0;
                end
            end
        end
        din_valid16 = 1'b0;
        check("x16_done", done16, 1);
        check("x16_busy", busy16, 0);
        check("x16_handshakes", hs16_cnt, 2);
        check("x16_scan_en_cycles", en16_cnt, CL16);
        check("x16_rb_strobes", rb16_cnt, 2);
        check("x16_rb_word0", rb16_log[0], 8'hEF);
        check("x16_rb_word1", rb16_log[1], 8'hBE);
        check("x16_chain_image", chain16, 16'hC35A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
